// File: rtl/dna_comparator_if.sv
// rtl/dna_comparator_if.sv - operand and result bundle for the DNA word comparator
interface dna_comparator_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] key;
    logic             match;
    logic [CNT_W-1:0] mismatch_count;
    logic             near_match;

    // Fetch side: presents operands, consumes results
    modport master (
        output data,
        output key,
        input  match,
        input  mismatch_count,
        input  near_match
    );

    // Comparator side
    modport slave (
        input  data,
        input  key,
        output match,
        output mismatch_count,
        output near_match
    );
endinterface

// File: rtl/dna_comparator.sv
// rtl/dna_comparator.sv - registered data/key equality compare, optional mismatch popcount (DNA_CMP_APPROX_EN)
module dna_comparator #(
    parameter int WIDTH     = 64,
    parameter int THRESHOLD = 2,
    localparam int CNT_W    = $clog2(WIDTH + 1)
) (
    input logic               clock,
    input logic               reset_n,
    dna_comparator_if.slave   bus
);

    // Operand width must hold whole bases and the threshold must be a valid count
    if (WIDTH < 2 || (WIDTH % 2) != 0 || THRESHOLD < 0) begin : g_bad_param
        $error("dna_comparator: WIDTH must be even and >= 2, THRESHOLD must be >= 0");
    end

`ifdef DNA_CMP_APPROX_EN
    localparam int LOG    = $clog2(WIDTH);
    localparam int LEAVES = 1 << LOG;

    logic [WIDTH-1:0] diff;
    logic [CNT_W-1:0] leaf [LEAVES];
    logic [CNT_W-1:0] sums [LOG+1][LEAVES];
    logic [CNT_W-1:0] count_next;
    logic             match_next;
    logic             near_next;
    logic [CNT_W-1:0] count_q;
    logic             match_q;
    logic             near_q;

    assign diff = bus.data ^ bus.key;

    // Each differing bit becomes a 1-valued leaf; the tree is padded to a power of two
    for (genvar gi = 0; gi < LEAVES; gi++) begin : g_leaf
        if (gi < WIDTH) begin : g_bit
            assign leaf[gi] = CNT_W'(diff[gi]);
        end else begin : g_pad
            assign leaf[gi] = '0;
        end
    end

    // Pairwise adder tree: level l holds LEAVES>>l partial sums, root is the full count
    always_comb begin
        for (int l = 0; l <= LOG; l++) begin
            for (int i = 0; i < LEAVES; i++) begin
                sums[l][i] = '0;
            end
        end
        for (int i = 0; i < LEAVES; i++) begin
            sums[0][i] = leaf[i];
        end
        for (int l = 1; l <= LOG; l++) begin
            for (int i = 0; i < (LEAVES >> l); i++) begin
                sums[l][i] = sums[l-1][2*i] + sums[l-1][2*i+1];
            end
        end
        count_next = sums[LOG][0];
    end

    assign match_next = (count_next == '0);
    assign near_next  = (32'(count_next) <= THRESHOLD);

    // Single result stage: match, count and near flag all land on the same edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            match_q <= 1'b0;
            count_q <= '0;
            near_q  <= 1'b0;
        end else begin
            match_q <= match_next;
            count_q <= count_next;
            near_q  <= near_next;
        end
    end

    assign bus.match          = match_q;
    assign bus.mismatch_count = count_q;
    assign bus.near_match     = near_q;
`else
    logic match_q;

    // Plain equality into one flop; no counting logic in this build
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            match_q <= 1'b0;
        end else begin
            match_q <= (bus.data == bus.key);
        end
    end

    assign bus.match          = match_q;
    assign bus.mismatch_count = '0;
    assign bus.near_match     = 1'b0;
`endif

endmodule

// File: tb/tb_dna_comparator.sv
// tb/tb_dna_comparator.sv - self-checking bench for dna_comparator (vectors, reset corners, random model)
module tb_dna_comparator;

    localparam int WIDTH     = 64;
    localparam int THRESHOLD = 2;
    localparam int CNT_W     = $clog2(WIDTH + 1);

    logic clock;
    logic reset_n;

    dna_comparator_if #(.WIDTH(WIDTH)) bus ();

    dna_comparator #(
        .WIDTH     (WIDTH),
        .THRESHOLD (THRESHOLD)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] key;
        logic             exp_match;
        int               exp_count;
        logic             exp_near;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference: equality, number of differing bit positions, threshold compare
    task automatic model(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] k,
                         output logic m, output int c, output logic n);
        int diffs;
        diffs = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (d[i] != k[i]) diffs++;
        end
        m = (diffs == 0);
`ifdef DNA_CMP_APPROX_EN
        c = diffs;
        n = (diffs <= THRESHOLD);
`else
        c = 0;
        n = 1'b0;
`endif
    endtask

    task automatic check_outputs(input string name, input logic m, input int c, input logic n);
        check({name, ".match"}, 64'(bus.match), 64'(m));
        check({name, ".count"}, 64'(bus.mismatch_count), 64'(c));
        check({name, ".near"},  64'(bus.near_match), 64'(n));
`ifdef DNA_CMP_APPROX_EN
        check({name, ".invariant"}, 64'(bus.match), 64'(bus.mismatch_count == '0));
`endif
    endtask

    task automatic check_zero(input string name);
        check({name, ".match"}, 64'(bus.match), 64'd0);
        check({name, ".count"}, 64'(bus.mismatch_count), 64'd0);
        check({name, ".near"},  64'(bus.near_match), 64'd0);
    endtask

    // Drive on the falling edge, sample just after the next rising edge
    task automatic apply(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] k);
        @(negedge clock);
        bus.data = d;
        bus.key  = k;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic             m;
        int               c;
        logic             n;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] k;

        vecs[0] = '{"identical",   64'h20C7A176AAFA69E7, 64'h20C7A176AAFA69E7, 1'b1, 0,  1'b1};
        vecs[1] = '{"bit48_flip",  64'h20C7A176AAFA69E7, 64'h20C6A176AAFA69E7, 1'b0, 1,  1'b1};
        vecs[2] = '{"short_key",   64'h20C7A176AAFA69E7, 64'h0000000000000008, 1'b0, 35, 1'b0};
        vecs[3] = '{"short_equal", 64'h0000000000000008, 64'h0000000000000008, 1'b1, 0,  1'b1};
        vecs[4] = '{"short_diff",  64'h000000000000000C, 64'h0000000000000008, 1'b0, 1,  1'b1};

        // Reset asserted from time zero with random operands applied
        reset_n  = 1'b0;
        bus.data = {$urandom, $urandom};
        bus.key  = {$urandom, $urandom};
        #3;
        check_zero("reset_initial");
        @(posedge clock);
        #1;
        check_zero("reset_held_edge");
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_zero("reset_release_hold");

        // Spec vectors applied on consecutive cycles
        for (int i = 0; i < 5; i++) begin
            apply(vecs[i].data, vecs[i].key);
`ifdef DNA_CMP_APPROX_EN
            check_outputs(vecs[i].name, vecs[i].exp_match, vecs[i].exp_count, vecs[i].exp_near);
`else
            check_outputs(vecs[i].name, vecs[i].exp_match, 0, 1'b0);
`endif
        end

        // Reset mid-operation between edges: clears at once, holds until first edge after release
        d = {$urandom, $urandom};
        apply(d, d);
        check("pre_reset.match", 64'(bus.match), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("reset_async");
        @(posedge clock);
        #1;
        check_zero("reset_mid_edge");
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_zero("reset_mid_release");
        @(posedge clock);
        #1;
        model(d, d, m, c, n);
        check_outputs("post_reset_first", m, c, n);

        // Randomized operands every falling edge against the reference
        for (int cyc = 0; cyc < 1000; cyc++) begin
            d = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       k = d;
                1:       k = d ^ (64'd1 << $urandom_range(0, WIDTH - 1));
                2:       k = d ^ (64'd1 << $urandom_range(0, WIDTH - 1))
                             ^ (64'd1 << $urandom_range(0, WIDTH - 1))
                             ^ (64'd1 << $urandom_range(0, WIDTH - 1));
                default: k = {$urandom, $urandom};
            endcase
            apply(d, k);
            model(d, k, m, c, n);
            check_outputs("random", m, c, n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dna_comparator.md
Name: dna_comparator

Overview:
- Registered equality comparator between a data word and a reference key, used in the DNA matching pipeline. Each base is 2 bits, so 64 bits hold 32 bases.
- Asserts `match` one clock after the operands are sampled.
- Optionally reports a bitwise mismatch count and a near-match flag for variation detection.
- Sits between the sequence-fetch stage and the match/variation reporting logic.

Parameters:
- WIDTH, 64, operand width in bits. Must be even and at least 2.
- THRESHOLD, 2, maximum mismatch count for which `near_match` asserts. Used only with the optional feature.
- CNT_W, $clog2(WIDTH+1), width of `mismatch_count`. Derived; do not override.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- data  in  WIDTH  sequence word under test.
- key  in  WIDTH  reference/template word.
- match  out  1  registered: data == key.
- mismatch_count  out  CNT_W  registered popcount of (data XOR key).
- near_match  out  1  registered: mismatch_count <= THRESHOLD.

Behaviour:
- Reset:
  - reset_n low forces match=0, mismatch_count=0 and near_match=0 immediately, with no clock needed.
  - On reset_n release, outputs hold these values until the first rising edge after release.
- Operands:
  - data and key are sampled on every rising edge. No enable and no handshake.
  - Operands narrower than WIDTH are zero-extended upstream, so a short key compares against the full data word.
  - Consequence: key=6'b001000 against 64-bit data that is nonzero above bit 5 gives match=0.
- Latency:
  - Exactly 1 cycle. Outputs after rising edge N reflect the operands present at edge N.
  - Outputs are stable for the whole following cycle.
  - Inputs are expected to change away from the rising edge (e.g. on the falling edge). Setup is the only requirement.
- match: 1 iff all WIDTH bits are equal. Comparison is purely combinational into a single flop; no pipelining.
- mismatch_count:
  - Sum of differing bit positions, range 0..WIDTH. It can never wrap because CNT_W covers WIDTH.
  - Implemented as an explicit adder tree over XOR bits, computed within one cycle.
- near_match: unsigned compare of the next-state count against THRESHOLD, registered in the same flop stage as the count.
- Consistency invariant on every cycle: match=1 iff mismatch_count=0.
  - With the optional feature disabled, only match is meaningful.
- Simultaneous operand change and reset: reset wins and outputs stay 0.
- Reset mid-operation: any pending result is discarded. The first valid result appears 1 cycle after the first post-reset edge.

Optional Feature:
- Macro: DNA_CMP_APPROX_EN.
- Defined:
  - mismatch_count and near_match are computed as described above.
  - match is derived as (next count == 0), sharing the XOR logic.
- Undefined:
  - No popcount or threshold logic is synthesized.
  - mismatch_count and near_match are tied to 0.
  - match is computed directly from (data == key).
  - Port list is identical in both builds; match timing is identical in both builds.

Test Plan:
1. Reset: reset_n=0 with random operands, asserted between clock edges -> match=0, mismatch_count=0 and near_match=0 immediately. Values hold until the first edge after release.
2. Identical words: data=key=64'h20C7A176AAFA69E7 -> after next rising edge, match=1, mismatch_count=0, near_match=1.
3. Single-bit difference: key changed at the falling edge to 64'h20C6A176AAFA69E7 (bit 48 flipped) -> at next edge, match=0, mismatch_count=1, near_match=1.
4. Short key: key=6'b001000 (zero-extended to 64'h8) with data unchanged -> match=0, mismatch_count=35, near_match=0.
5. Short operands: data=6'b001000 then data=6'b001100 on successive falling edges, key=8 -> first match=1 and count=0; next cycle match=0, count=1, near_match=1.
6. Latency and invariant: randomized operands changed on every falling edge for 1000 cycles -> outputs equal a 1-cycle-delayed model. match==(mismatch_count==0) always; repeat with DNA_CMP_APPROX_EN undefined (count and near_match remain 0).
